// File: rtl/icache_nway_refill.sv
// N-way set-associative instruction cache with a per-word refill FSM,
// age-based LRU replacement and a one-set-per-cycle flush walker.
// Hits are served combinationally; misses and flushes stall fetch.
module icache_nway_refill #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int WAYS       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_req,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_out,
  output logic              hit,
  output logic              stall,
  output logic              flush_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WOFF   = $clog2(LINE_WORDS);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - WOFF - IDX - 1;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = TAG_W + IDX;

  localparam logic [WOFF-1:0]  LAST_BEAT = WOFF'(LINE_WORDS - 1);
  localparam logic [IDX-1:0]   LAST_SET  = IDX'(SETS - 1);
  localparam logic [WAY_W-1:0] OLDEST    = WAY_W'(WAYS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_FLUSH  = 2'd2;

  // Fetch address split; bit 0 is a byte offset inside a 2-byte word.
  logic [WOFF-1:0]  word;
  logic [IDX-1:0]   idx;
  logic [TAG_W-1:0] tag;
  logic             addr_unused;
  assign word        = addr[WOFF:1];
  assign idx         = addr[WOFF+IDX:WOFF+1];
  assign tag         = addr[ADDR_W-1:WOFF+IDX+1];
  assign addr_unused = addr[0];

  // Control state
  logic [1:0]        state_q, state_d;
  logic [WOFF-1:0]   beat_q, beat_d;
  logic [IDX-1:0]    set_q, set_d;
  logic              flush_pend_q, flush_pend_d;
  logic [LINE_W-1:0] miss_line_q, miss_line_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [WAYS-1:0][SETS-1:0]             valid_q, valid_d;
  logic [WAYS-1:0][SETS-1:0][WAY_W-1:0]  age_q, age_d;

  // Tag and data storage: never reset, only qualified by valid bits
  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS][SETS*LINE_WORDS];

  logic [IDX-1:0]   miss_idx;
  logic [TAG_W-1:0] miss_tag;
  assign miss_idx = miss_line_q[IDX-1:0];
  assign miss_tag = miss_line_q[LINE_W-1:IDX];

  // Per-way tag compare against the looked-up set
  logic [WAYS-1:0] way_hit;
  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_way
      assign way_hit[gw] = valid_q[gw][idx] && (tag_mem[gw][idx] == tag);
    end
  endgenerate

  // Lowest-numbered hitting way (at most one can match in practice)
  logic [WAY_W-1:0] hit_way;
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (way_hit[w]) hit_way = WAY_W'(w);
  end

  assign hit        = rd_req && (state_q == S_IDLE) && (|way_hit);
  assign inst_out   = hit ? data_mem[hit_way][{idx, word}] : '0;
  assign stall      = (state_q != S_IDLE) || (rd_req && !hit) || flush_pend_q;
  assign flush_busy = (state_q == S_FLUSH);
  assign mem_req    = (state_q == S_REFILL);
  assign mem_addr   = (state_q == S_REFILL) ? {miss_line_q, beat_q, 1'b0} : '0;

  // Victim: lowest invalid way, otherwise the oldest way of the set
  logic             inv_any;
  logic [WAY_W-1:0] inv_way, old_way, victim;
  always_comb begin
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][idx]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    for (int w = 0; w < WAYS; w++)
      if (age_q[w][idx] == OLDEST) old_way = WAY_W'(w);
    victim = inv_any ? inv_way : old_way;
  end

  // Next-state: FSM, valid bits and ages
  logic             upd_en;
  logic [IDX-1:0]   upd_set;
  logic [WAY_W-1:0] upd_way;
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    set_d        = set_q;
    flush_pend_d = flush_pend_q;
    miss_line_d  = miss_line_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    age_d        = age_q;
    upd_en       = 1'b0;
    upd_set      = idx;
    upd_way      = hit_way;
    case (state_q)
      S_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = S_FLUSH;
          set_d        = '0;
          flush_pend_d = 1'b0;
        end else if (rd_req && !hit) begin
          miss_line_d = {tag, idx};
          victim_d    = victim;
          beat_d      = '0;
          state_d     = S_REFILL;
        end else if (rd_req && hit) begin
          upd_en = 1'b1;
        end
      end
      S_REFILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (mem_rvalid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            valid_d[victim_q][miss_idx] = 1'b1;
            upd_en  = 1'b1;
            upd_set = miss_idx;
            upd_way = victim_q;
            state_d = S_IDLE;
          end
        end
      end
      S_FLUSH: begin
        if (flush) flush_pend_d = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
          valid_d[w][set_q] = 1'b0;
          age_d[w][set_q]   = WAY_W'(w);
        end
        set_d = set_q + 1'b1;
        if (set_q == LAST_SET) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Touched way becomes youngest; ways younger than it age by one
    if (upd_en)
      for (int v = 0; v < WAYS; v++) begin
        if (WAY_W'(v) == upd_way)
          age_d[v][upd_set] = '0;
        else if (age_q[v][upd_set] < age_q[upd_way][upd_set])
          age_d[v][upd_set] = age_q[v][upd_set] + 1'b1;
      end
  end

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      set_q        <= '0;
      flush_pend_q <= 1'b0;
      miss_line_q  <= '0;
      victim_q     <= '0;
      valid_q      <= '0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          age_q[w][s] <= WAY_W'(w);
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      set_q        <= set_d;
      flush_pend_q <= flush_pend_d;
      miss_line_q  <= miss_line_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
    end
  end

  // Refill writes: one data word per accepted beat, tag on the last beat
  always_ff @(posedge clk) begin
    if ((state_q == S_REFILL) && mem_rvalid) begin
      data_mem[victim_q][{miss_idx, beat_q}] <= mem_rdata;
      if (beat_q == LAST_BEAT) tag_mem[victim_q][miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_nway_refill.sv
// Scenario bench for icache_nway_refill: a 2-way/64-set instance and a
// 4-way/4-set instance share stimulus, selected by 'sel'. A memory model
// answers refills and checks each requested address against a queue.
module tb_icache_nway_refill;

  logic        clk = 1'b0;
  logic        rst, rd_req, flush, mem_rvalid, sel;
  logic [15:0] addr, mem_rdata;
  int          gap, wait_cnt;
  int          checks, errors;
  logic [15:0] exp_addr_q[$];
  logic [15:0] exp_inst_q[$];

  logic        a_rd, a_fl, a_rv, b_rd, b_fl, b_rv;
  logic [15:0] a_inst, b_inst, a_maddr, b_maddr;
  logic        a_hit, b_hit, a_stall, b_stall, a_fb, b_fb, a_mreq, b_mreq;
  logic [15:0] inst_out, mem_addr;
  logic        hit, stall, flush_busy, mem_req;

  assign a_rd = rd_req & ~sel;
  assign a_fl = flush & ~sel;
  assign a_rv = mem_rvalid & ~sel;
  assign b_rd = rd_req & sel;
  assign b_fl = flush & sel;
  assign b_rv = mem_rvalid & sel;

  assign inst_out   = sel ? b_inst  : a_inst;
  assign hit        = sel ? b_hit   : a_hit;
  assign stall      = sel ? b_stall : a_stall;
  assign flush_busy = sel ? b_fb    : a_fb;
  assign mem_req    = sel ? b_mreq  : a_mreq;
  assign mem_addr   = sel ? b_maddr : a_maddr;

  icache_nway_refill dut_a (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(a_rd), .flush(a_fl),
    .inst_out(a_inst), .hit(a_hit), .stall(a_stall), .flush_busy(a_fb),
    .mem_req(a_mreq), .mem_addr(a_maddr), .mem_rvalid(a_rv), .mem_rdata(mem_rdata)
  );

  icache_nway_refill #(.SETS(4), .WAYS(4)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .rd_req(b_rd), .flush(b_fl),
    .inst_out(b_inst), .hit(b_hit), .stall(b_stall), .flush_busy(b_fb),
    .mem_req(b_mreq), .mem_addr(b_maddr), .mem_rvalid(b_rv), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: 0xA000 + word for line 0x0040, distinct per line elsewhere
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = 16'h0000;
    w[2:0] = a[3:1];
    return 16'hA000 + ((a - 16'h0040) & 16'hFFF0) + w;
  endfunction

  // Memory model: one word per beat, 'gap' idle cycles after each accepted word
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_rvalid = 1'b0;
      wait_cnt   = 0;
    end else begin
      if (mem_rvalid) wait_cnt = gap;
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_addr_unexpected: got %h required none", mem_addr);
      end else if (mem_addr !== exp_addr_q[0]) begin
        errors++;
        $display("FAIL mem_addr: got %h required %h", mem_addr, exp_addr_q[0]);
      end
      if (wait_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word(mem_addr);
        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        wait_cnt--;
      end
    end
  end

  // Present a lookup and hold it until hit (bounded); counts stalled cycles
  task automatic lookup(input logic [15:0] a, input bit miss,
                        output int stall_cyc, output logic h, output logic [15:0] d);
    int cyc;
    @(negedge clk);
    addr   = a;
    rd_req = 1'b1;
    if (miss)
      for (int k = 0; k < 8; k++) exp_addr_q.push_back((a & 16'hFFF0) + 16'(2 * k));
    exp_inst_q.push_back(mem_word(a));
    #1;
    cyc = 0;
    stall_cyc = 0;
    while (hit !== 1'b1 && cyc < 300) begin
      if (stall === 1'b1) stall_cyc++;
      @(negedge clk);
      #1;
      cyc++;
    end
    h = hit;
    d = inst_out;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  // Single-cycle lookup that is withdrawn before the clock edge
  task automatic probe(input logic [15:0] a, output logic h);
    @(negedge clk);
    addr   = a;
    rd_req = 1'b1;
    #1;
    h = hit;
    rd_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rd_req = 1'b1;
    addr = 16'h0046;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b required 0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr: got %h required 0000", mem_addr); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy: got %b required 0", flush_busy); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b required 0", hit); end
    checks++; if (inst_out !== 16'h0) begin errors++; $display("FAIL reset_inst_out: got %h required 0000", inst_out); end
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_cold_miss;
    int sc; logic h; logic [15:0] d, e;
    lookup(16'h0046, 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9) begin errors++; $display("FAIL cold_stall_cycles: got %0d required 9", sc); end
    checks++; if (h !== 1'b1) begin errors++; $display("FAIL cold_hit: got %b required 1", h); end
    checks++; if (d !== 16'hA003) begin errors++; $display("FAIL cold_inst: got %h required a003", d); end
    checks++; if (d !== e) begin errors++; $display("FAIL cold_inst_model: got %h required %h", d, e); end
    checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL cold_beats_left: got %0d required 0", exp_addr_q.size()); end
  endtask

  task automatic test_gapped;
    int sc; logic h; logic [15:0] d, e;
    gap = 3;
    lookup(16'h0086, 1'b1, sc, h, d);
    gap = 0;
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 30) begin errors++; $display("FAIL gap_stall_cycles: got %0d required 30", sc); end
    checks++; if (h !== 1'b1 || d !== e) begin errors++; $display("FAIL gap_hit: got %b/%h required 1/%h", h, d, e); end
    lookup(16'h008E, 1'b0, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 0 || h !== 1'b1 || d !== e) begin errors++; $display("FAIL gap_last_word: got %0d/%b/%h required 0/1/%h", sc, h, d, e); end
  endtask

  task automatic test_lru;
    int sc; logic h; logic [15:0] d, e;
    lookup(16'h0440, 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9 || d !== e) begin errors++; $display("FAIL lru_fill_440: got %0d/%h required 9/%h", sc, d, e); end
    lookup(16'h0040, 1'b0, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 0 || d !== e) begin errors++; $display("FAIL lru_touch_040: got %0d/%h required 0/%h", sc, d, e); end
    lookup(16'h0840, 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9 || d !== e) begin errors++; $display("FAIL lru_fill_840: got %0d/%h required 9/%h", sc, d, e); end
    lookup(16'h0040, 1'b0, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 0 || d !== e) begin errors++; $display("FAIL lru_keep_040: got %0d/%h required 0/%h", sc, d, e); end
    probe(16'h0440, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL lru_evict_440: got hit %b required 0", h); end
  endtask

  task automatic test_4way;
    int sc; logic h; logic [15:0] d, e;
    logic [15:0] tags[6];
    tags = '{16'h0100, 16'h0140, 16'h0180, 16'h01C0, 16'h0200, 16'h0240};
    sel = 1'b1;
    for (int t = 0; t < 4; t++) begin
      lookup(tags[t], 1'b1, sc, h, d);
      e = exp_inst_q.pop_front();
      checks++; if (sc !== 9 || d !== e) begin errors++; $display("FAIL w4_fill%0d: got %0d/%h required 9/%h", t, sc, d, e); end
    end
    lookup(tags[0], 1'b0, sc, h, d);
    void'(exp_inst_q.pop_front());
    lookup(tags[4], 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9 || d !== e) begin errors++; $display("FAIL w4_fill4: got %0d/%h required 9/%h", sc, d, e); end
    probe(tags[1], h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL w4_evict_tag1: got hit %b required 0", h); end
    for (int t = 0; t < 5; t++) begin
      if (t == 1) continue;
      lookup(tags[t], 1'b0, sc, h, d);
      e = exp_inst_q.pop_front();
      checks++; if (sc !== 0 || d !== e) begin errors++; $display("FAIL w4_keep%0d: got %0d/%h required 0/%h", t, sc, d, e); end
    end
    // Touch order 0,2,3,4 leaves tag0 oldest
    lookup(tags[5], 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9 || d !== e) begin errors++; $display("FAIL w4_fill5: got %0d/%h required 9/%h", sc, d, e); end
    probe(tags[0], h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL w4_evict_tag0: got hit %b required 0", h); end
    sel = 1'b0;
  endtask

  task automatic test_flush_refill;
    int n, b; logic h;
    @(negedge clk);
    addr = 16'h00C0;
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) exp_addr_q.push_back(16'h00C0 + 16'(2 * k));
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (mem_addr !== 16'h00C4) begin errors++; $display("FAIL fr_beat2_addr: got %h required 00c4", mem_addr); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n = 0;
    while (flush_busy !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    checks++; if (n !== 6) begin errors++; $display("FAIL fr_flush_start: got %0d cycles required 6", n); end
    checks++; if (exp_addr_q.size() != 0) begin errors++; $display("FAIL fr_refill_done: got %0d beats left required 0", exp_addr_q.size()); end
    b = 0;
    while (flush_busy === 1'b1 && b < 200) begin b++; @(negedge clk); #1; end
    checks++; if (b !== 64) begin errors++; $display("FAIL fr_flush_len: got %0d required 64", b); end
    probe(16'h00C0, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL fr_line_gone: got hit %b required 0", h); end
    probe(16'h0040, h);
    checks++; if (h !== 1'b0) begin errors++; $display("FAIL fr_old_line_gone: got hit %b required 0", h); end
  endtask

  task automatic test_flush_twice;
    int busy;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    busy = 0;
    for (int i = 0; i < 150; i++) begin
      if (flush_busy === 1'b1) busy++;
      @(negedge clk);
      flush = (i == 9);
      #1;
    end
    checks++; if (busy !== 128) begin errors++; $display("FAIL ff_busy_cycles: got %0d required 128", busy); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL ff_end_idle: got %b required 0", flush_busy); end
  endtask

  task automatic test_reset_mid;
    int sc; logic h; logic [15:0] d, e;
    @(negedge clk);
    addr = 16'h00C0;
    rd_req = 1'b1;
    for (int k = 0; k < 8; k++) exp_addr_q.push_back(16'h00C0 + 16'(2 * k));
    @(negedge clk);
    rd_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (mem_addr !== 16'h00CA) begin errors++; $display("FAIL rm_beat5_addr: got %h required 00ca", mem_addr); end
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_mem_req_async: got %b required 0", mem_req); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rm_mem_addr_async: got %h required 0000", mem_addr); end
    exp_addr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    lookup(16'h00C0, 1'b1, sc, h, d);
    e = exp_inst_q.pop_front();
    checks++; if (sc !== 9 || h !== 1'b1 || d !== e) begin errors++; $display("FAIL rm_restart: got %0d/%b/%h required 9/1/%h", sc, h, d, e); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; rd_req = 1'b0; flush = 1'b0; addr = 16'h0;
    mem_rvalid = 1'b0; mem_rdata = 16'h0; sel = 1'b0; gap = 0; wait_cnt = 0;
    test_reset;
    test_cold_miss;
    test_gapped;
    test_lru;
    test_4way;
    test_flush_refill;
    test_flush_twice;
    test_reset_mid;
    checks++; if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d/%0d required 0/0", exp_addr_q.size(), exp_inst_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
